// File: rtl/ternary_host_driver_if.sv
// Host <-> driver bundle: weight/activation/result handshakes plus the
// accelerator pin group. The host (or bench) holds the master side.
interface ternary_host_driver_if #(
  parameter int IN_LEN    = 12,
  parameter int OUT_LEN   = 6,
  parameter int BIT_WIDTH = 8,
  parameter int W_WIDTH   = 2
);
  logic                                cfg_valid;
  logic                                cfg_ready;
  logic [W_WIDTH*IN_LEN*OUT_LEN-1:0]   cfg_weights;
  logic                                act_valid;
  logic                                act_ready;
  logic [IN_LEN*BIT_WIDTH-1:0]         act_data;
  logic                                res_valid;
  logic                                res_ready;
  logic [OUT_LEN*BIT_WIDTH-1:0]        res_data;
  logic                                acc_rst_n;
  logic [15:0]                         acc_in;
  logic [OUT_LEN-1:0]                  acc_out;

  modport master (
    output cfg_valid, cfg_weights, act_valid, act_data, res_ready, acc_out,
    input  cfg_ready, act_ready, res_valid, res_data, acc_rst_n, acc_in
  );

  modport slave (
    input  cfg_valid, cfg_weights, act_valid, act_data, res_ready, acc_out,
    output cfg_ready, act_ready, res_valid, res_data, acc_rst_n, acc_in
  );
endinterface

// File: rtl/ternary_host_driver.sv
// Host-side sequencer for the ternary matmul accelerator: resets it, loads
// the weight set slice by slice, streams activation bit-planes in step with
// the accelerator's mod-8 counter, and deserializes the result streams.
//
// state | meaning
// IDLE  | accelerator held in reset, waiting for a weight set
// RSTP  | one-cycle accelerator reset pulse before loading
// LOAD  | one weight slice per cycle on acc_in
// MULT  | phase counter mirrors the accelerator; vectors stream here
module ternary_host_driver #(
  parameter int IN_LEN    = 12,
  parameter int OUT_LEN   = 6,
  parameter int BIT_WIDTH = 8,
  parameter int W_WIDTH   = 2,
  parameter int OUT_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ternary_host_driver_if.slave  bus
);
  localparam int NSLICE = W_WIDTH * OUT_LEN;
  localparam int CNT_W  = $clog2(NSLICE);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);
  // elapsed-cycle counter covers streaming plus the output latency
  localparam logic [3:0] CAP_FIRST = 4'(OUT_LAT);
  localparam logic [3:0] CAP_LAST  = 4'(OUT_LAT + BIT_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RSTP, LOAD, MULT} state_t;

  state_t                            state_q, state_d;
  logic [NSLICE*IN_LEN-1:0]          wts_q, wts_d;
  logic [IN_LEN*BIT_WIDTH-1:0]       act_q, act_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [2:0]                        phase_q, phase_d;
  logic                              inflight_q, inflight_d;
  logic [3:0]                        el_q, el_d;
  logic                              acc_rst_n_q, acc_rst_n_d;
  logic [IN_LEN-1:0]                 acc_in_q, acc_in_d;
  logic                              cfg_ready_q, cfg_ready_d;
  logic                              act_ready_q, act_ready_d;
  logic                              res_valid_q, res_valid_d;
  logic [OUT_LEN*BIT_WIDTH-1:0]      res_data_q, res_data_d;
  logic [2:0]                        cap_k;

  logic cfg_fire, act_fire, res_fire;

  // a weight set on cfg_valid always wins over a waiting activation vector
  assign cfg_fire = bus.cfg_valid & cfg_ready_q;
  assign act_fire = bus.act_valid & act_ready_q & ~bus.cfg_valid;
  assign res_fire = res_valid_q & bus.res_ready;
  assign cap_k    = 3'(el_q - CAP_FIRST);

  function automatic logic [IN_LEN-1:0] plane(input logic [IN_LEN*BIT_WIDTH-1:0] v,
                                               input logic [2:0] k);
    logic [IN_LEN-1:0] p;
    for (int i = 0; i < IN_LEN; i++) p[i] = v[i*BIT_WIDTH + int'(k)];
    return p;
  endfunction

  // next-state and next-output computation for every register
  always_comb begin
    state_d     = state_q;
    wts_d       = wts_q;
    act_d       = act_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    inflight_d  = inflight_q;
    el_d        = el_q;
    acc_rst_n_d = acc_rst_n_q;
    acc_in_d    = '0;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q & ~res_fire;

    case (state_q)
      IDLE: begin
        acc_rst_n_d = 1'b0;
        phase_d     = '0;
      end
      RSTP: begin
        state_d     = LOAD;
        cnt_d       = '0;
        acc_rst_n_d = 1'b1;
        acc_in_d    = wts_q[0 +: IN_LEN];
        phase_d     = '0;
      end
      LOAD: begin
        phase_d = '0;
        if (cnt_q == LAST_SLICE) begin
          state_d = MULT;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          acc_in_d = wts_q[int'(cnt_d)*IN_LEN +: IN_LEN];
        end
      end
      MULT: begin
        phase_d = phase_q + 3'd1;
        if (inflight_q) begin
          el_d = el_q + 4'd1;
          if (el_q < 4'd7) acc_in_d = plane(act_q, el_q[2:0] + 3'd1);
          if (el_q >= CAP_FIRST && el_q <= CAP_LAST) begin
            for (int j = 0; j < OUT_LEN; j++)
              res_data_d[j*BIT_WIDTH + int'(cap_k)] = bus.acc_out[j];
          end
          if (el_q == CAP_LAST) begin
            inflight_d  = 1'b0;
            res_valid_d = 1'b1;
          end
        end else if (act_fire) begin
          inflight_d = 1'b1;
          el_d       = '0;
          act_d      = bus.act_data;
          acc_in_d   = plane(bus.act_data, 3'd0);
        end
      end
      default: state_d = IDLE;
    endcase

    // cfg_ready is only high while idle or MULT with nothing in flight
    if (cfg_fire) begin
      state_d     = RSTP;
      wts_d       = bus.cfg_weights;
      acc_rst_n_d = 1'b0;
      acc_in_d    = '0;
      inflight_d  = 1'b0;
    end

    cfg_ready_d = (state_d == IDLE) || (state_d == MULT && !inflight_d);
    act_ready_d = (state_d == MULT) && (phase_d == 3'd7) && !inflight_d && !res_valid_d;
  end

  // all state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wts_q       <= '0;
      act_q       <= '0;
      cnt_q       <= '0;
      phase_q     <= '0;
      inflight_q  <= 1'b0;
      el_q        <= '0;
      acc_rst_n_q <= 1'b0;
      acc_in_q    <= '0;
      cfg_ready_q <= 1'b1;
      act_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wts_q       <= wts_d;
      act_q       <= act_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      inflight_q  <= inflight_d;
      el_q        <= el_d;
      acc_rst_n_q <= acc_rst_n_d;
      acc_in_q    <= acc_in_d;
      cfg_ready_q <= cfg_ready_d;
      act_ready_q <= act_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.act_ready = act_ready_q & ~bus.cfg_valid;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.acc_rst_n = acc_rst_n_q;
  assign bus.acc_in    = 16'(acc_in_q);
endmodule

// File: tb/tb_ternary_host_driver.sv
// Directed bench for ternary_host_driver with a one-cycle-latency stub
// accelerator that echoes acc_in[5:0] onto acc_out, so lane j of a result
// equals activation element j.
module tb_ternary_host_driver;
  localparam logic [143:0] W1 = 144'h0123456789ABCDEF0123456789ABCDEF0123;
  localparam logic [143:0] W2 = 144'hFEDCBA98765432100F1E2D3C4B5A69788796;
  localparam logic [95:0]  V1 = {12{8'hA5}};
  localparam logic [95:0]  V2 = 96'h123456789ABCDEF0C3E1F00F;
  localparam logic [95:0]  V3 = 96'hFFEEDDCCBBAA998877665544;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] stub_q = '0;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mult0    = 0;

  ternary_host_driver_if bus();

  ternary_host_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) stub_q <= bus.acc_in[5:0];
  assign bus.acc_out = stub_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [11:0] plane(input logic [95:0] v, input int k);
    logic [11:0] p;
    for (int i = 0; i < 12; i++) p[i] = v[i*8 + k];
    return p;
  endfunction

  task automatic check_reset_vals();
    check("rst_acc_rst_n", 64'(bus.acc_rst_n), 64'd0);
    check("rst_acc_in",    64'(bus.acc_in),    64'd0);
    check("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    check("rst_act_ready", 64'(bus.act_ready), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data",  64'(bus.res_data),  64'd0);
  endtask

  task automatic do_cfg(input logic [143:0] w, input logic with_act, input logic [95:0] v);
    check("cfg_ready_pre", 64'(bus.cfg_ready), 64'd1);
    bus.cfg_weights = w;
    bus.cfg_valid   = 1'b1;
    if (with_act) begin
      bus.act_data  = v;
      bus.act_valid = 1'b1;
      #1;
      check("act_ready_prio", 64'(bus.act_ready), 64'd0);
    end
    tick();
    bus.cfg_valid = 1'b0;
    bus.act_valid = 1'b0;
    check("rstp_rst_n",     64'(bus.acc_rst_n), 64'd0);
    check("rstp_acc_in",    64'(bus.acc_in),    64'd0);
    check("rstp_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    for (int c = 0; c < 12; c++) begin
      tick();
      check("load_acc_in", 64'(bus.acc_in),    64'(w[c*12 +: 12]));
      check("load_rst_n",  64'(bus.acc_rst_n), 64'd1);
    end
    tick();
    mult0 = cyc;
    check("mult_acc_in",    64'(bus.acc_in),    64'd0);
    check("mult_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    check("mult_act_ready", 64'(bus.act_ready), 64'd0);
  endtask

  // act_ready must appear exactly at the first phase-7 cycle from now
  task automatic wait_act_ready();
    int start;
    int exp_cyc;
    int n;
    start   = cyc;
    exp_cyc = start + (7 - ((start - mult0) % 8));
    n       = 0;
    while (!bus.act_ready && n < 20) begin
      tick();
      n++;
    end
    check("act_ready_cycle", 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic send_vec(input logic [95:0] v);
    bus.act_data  = v;
    bus.act_valid = 1'b1;
    tick();
    bus.act_valid = 1'b0;
    bus.act_data  = ~v;
    check("stream_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      check("stream_acc_in", 64'(bus.acc_in), 64'(plane(v, k)));
    end
    tick();
    check("post_acc_in",     64'(bus.acc_in),    64'd0);
    check("res_valid_early", 64'(bus.res_valid), 64'd0);
    tick();
    check("res_valid",       64'(bus.res_valid), 64'd1);
    check("res_data",        64'(bus.res_data),  64'(v[47:0]));
    check("cfg_ready_done",  64'(bus.cfg_ready), 64'd1);
  endtask

  initial begin
    bus.cfg_valid   = 1'b0;
    bus.cfg_weights = '0;
    bus.act_valid   = 1'b0;
    bus.act_data    = '0;
    bus.res_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    tick();

    // load, first vector, hand-checked A5 bit-planes
    do_cfg(W1, 1'b0, '0);
    wait_act_ready();
    send_vec(V1);

    // result held under back-pressure; no new vector accepted meanwhile
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_valid",     64'(bus.res_valid), 64'd1);
      check("hold_data",      64'(bus.res_data),  64'h0000_A5A5_A5A5_A5A5);
      check("hold_act_ready", 64'(bus.act_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("res_freed", 64'(bus.res_valid), 64'd0);
    wait_act_ready();

    // cfg and act together at phase 7: cfg wins
    do_cfg(W2, 1'b1, V2);
    wait_act_ready();
    send_vec(V2);

    // reload with a pending result: result survives
    do_cfg(W1, 1'b0, '0);
    check("pend_valid", 64'(bus.res_valid), 64'd1);
    check("pend_data",  64'(bus.res_data),  64'(V2[47:0]));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("pend_act_ready", 64'(bus.act_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("pend_freed", 64'(bus.res_valid), 64'd0);
    wait_act_ready();

    // reset in the middle of streaming bit 4
    bus.act_data  = V3;
    bus.act_valid = 1'b1;
    tick();
    bus.act_valid = 1'b0;
    repeat (4) tick();
    check("bit4_acc_in", 64'(bus.acc_in), 64'(plane(V3, 4)));
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid",  64'(bus.res_valid), 64'd0);
    check("post_rst_rst_n",  64'(bus.acc_rst_n), 64'd0);
    check("post_rst_cfg_rd", 64'(bus.cfg_ready), 64'd1);

    // normal sequencing after reset
    do_cfg(W2, 1'b0, '0);
    wait_act_ready();
    send_vec(V3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
